// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO: store-and-forward by default, falling back to cut-through
// when a single packet is larger than the storage and would otherwise deadlock.
module axis_pkt_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [$clog2(DEPTH):0]  level,
   output logic [$clog2(DEPTH):0]  pkt_count,
   output logic                    oversize
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned MW = DATA_WIDTH + 1;

   typedef enum logic {ST_STORE, ST_PASS} state_t;

   state_t          state;
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [MW-1:0]   mem [DEPTH];

   logic            wr_en;
   logic            rd_en;
   logic            wr_eop;
   logic            rd_eop;

   assign s_axis_tready = (level != LW'(DEPTH));
   assign m_axis_tvalid = (state == ST_PASS) ? (level != '0) : (pkt_count != '0);
   assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];

   assign wr_en  = s_axis_tvalid & s_axis_tready;
   assign rd_en  = m_axis_tvalid & m_axis_tready;
   assign wr_eop = wr_en & s_axis_tlast;
   assign rd_eop = rd_en & m_axis_tlast;

   // Storage array carries tlast alongside data and is intentionally not reset.
   always_ff @(posedge axis_aclk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         pkt_count <= '0;
         state     <= ST_STORE;
         oversize  <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + LW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + LW'(1);
         end
         level     <= level + LW'(wr_en) - LW'(rd_en);
         pkt_count <= pkt_count + LW'(wr_eop) - LW'(rd_eop);
         oversize  <= 1'b0;

         // A full FIFO holding no complete packet can only drain by cutting through.
         case (state)
            ST_STORE: begin
               if ((level == LW'(DEPTH)) && (pkt_count == '0)) begin
                  state    <= ST_PASS;
                  oversize <= 1'b1;
               end
            end
            ST_PASS: begin
               if (rd_eop) begin
                  state <= ST_STORE;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, tdata width in bits.
REQ-002 Parameter DEPTH, default 16, storage in beats; power of two, >= 4; AW = log2(DEPTH).
REQ-003 axis_aclk  input  1  single clock; all logic on rising edge.
REQ-004 axis_areset  input  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata  input  DATA_WIDTH  write beat data, from the arbiter's merged master output.
REQ-006 s_axis_tvalid  input  1  write beat valid.
REQ-007 s_axis_tready  output  1  FIFO can accept a beat.
REQ-008 s_axis_tlast  input  1  last beat of packet.
REQ-009 m_axis_tdata  output  DATA_WIDTH  head-of-FIFO data.
REQ-010 m_axis_tvalid  output  1  head beat is releasable.
REQ-011 m_axis_tready  input  1  downstream accepts.
REQ-012 m_axis_tlast  output  1  tlast stored with head beat.
REQ-013 level  output  AW+1  beats stored, 0..DEPTH.
REQ-014 pkt_count  output  AW+1  complete packets stored, 0..DEPTH.
REQ-015 oversize  output  1  one-cycle pulse on STORE->PASS entry.

Function
REQ-016 Write handshake: s_axis_tvalid & s_axis_tready; tdata and tlast stored together at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-017 s_axis_tready = (level != DEPTH), combinational from registered state; no dependence on s_axis_tvalid.
REQ-018 Read handshake: m_axis_tvalid & m_axis_tready; rd_ptr increments modulo DEPTH.
REQ-019 First-word fall-through: m_axis_tdata and m_axis_tlast reflect mem[rd_ptr] whenever level != 0; don't-care when empty.
REQ-020 Pointers AW+1 bits; empty when equal; full when low AW bits equal and MSBs differ.
REQ-021 Simultaneous write and read in one cycle: both complete; level unchanged; legal when full (read frees a slot only next cycle, so write accepted only if not full at that edge) and when empty (write accepted; read not, as tvalid=0).
REQ-022 pkt_count +1 on accepted write with tlast=1; -1 on accepted read with tlast=1; both in the same cycle -> unchanged.
REQ-023 State machine, two states: STORE (default), PASS.
REQ-024 STORE: m_axis_tvalid = (pkt_count != 0); store-and-forward, no beat of a packet released before its tlast beat is written.
REQ-025 STORE->PASS when level == DEPTH and pkt_count == 0 (oversize packet would deadlock); oversize pulses high the cycle after the transition edge, for exactly one cycle.
REQ-026 PASS: m_axis_tvalid = (level != 0); cut-through until the head packet's tlast beat is read.
REQ-027 PASS->STORE on accepted read with m_axis_tlast=1; same edge takes effect next cycle.
REQ-028 Latency: tlast beat written at edge N -> m_axis_tvalid high in cycle N+1 (STORE, previously no packet stored).
REQ-029 m_axis_tvalid, once high, stays high until handshake; data stable while stalled.
REQ-030 level and pkt_count registered, updated at the same edge as the pointers.

Reset
REQ-031 axis_areset high at a rising edge: pointers, level, pkt_count = 0; state = STORE; oversize = 0; next cycle s_axis_tready = 1, m_axis_tvalid = 0.
REQ-032 Reset mid-packet discards all stored beats, partial and complete; storage array not cleared.
REQ-033 Reset has priority over any simultaneous handshake.

Verification
REQ-034 Single packet: write 0..3, tlast on 3, m_axis_tready=1 -> m_axis_tvalid stays 0 until cycle after beat 3 written; then 0,1,2,3 out on consecutive cycles, tlast only on 3; pkt_count 1->0.
REQ-035 Store-and-forward hold: write 10 beats of a 12-beat packet, pause -> m_axis_tvalid=0, level=10; finish -> 12 beats out in order.
REQ-036 Full/backpressure: m_axis_tready=0, write 16 one-beat packets -> s_axis_tready=0 with level=16, pkt_count=16; release -> 16 beats out in order, level returns 0.
REQ-037 Oversize: DEPTH=16, write 20-beat packet, m_axis_tready=1 after fill -> oversize pulses once, all 20 beats delivered in order, state back to STORE, pkt_count=0.
REQ-038 Simultaneous events: steady write+read streaming of 1-beat packets -> level and pkt_count constant, no beat lost or duplicated (scoreboard).
REQ-039 Reset mid-packet: assert axis_areset after 5 beats of an 8-beat packet -> level=0, pkt_count=0, m_axis_tvalid=0 next cycle; subsequent packet passes unaffected.
